fifo_nonlookahead_to_lookahead: RTL and testbench

// Converts a non-lookahead (registered-read) FIFO read port into a lookahead (first-word-fall-through) read port.

---
 rtl/fifo_nonlookahead_to_lookahead_if.sv | 22 ++
 rtl/fifo_nonlookahead_to_lookahead.sv | 49 ++++
 tb/tb_fifo_nonlookahead_to_lookahead.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_nonlookahead_to_lookahead_if.sv
// Read-port bundle for the registered-read to first-word-fall-through converter.
// Underscore-prefixed signals face the upstream FIFO; the rest face the consumer.
interface fifo_nonlookahead_to_lookahead_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  _empty;
    logic                  _rd;
    logic [DATA_WIDTH-1:0] _dout;
    logic                  empty;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        input  _empty, _dout, rd,
        output _rd, empty, dout
    );

    modport slave (
        output _empty, _dout, rd,
        input  _rd, empty, dout
    );
endinterface

// File: rtl/fifo_nonlookahead_to_lookahead.sv
// Turns a registered-read FIFO port into a lookahead port with a 2-entry skid buffer,
// sustaining one word per cycle once the 2-cycle fill latency has elapsed.
module fifo_nonlookahead_to_lookahead #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    fifo_nonlookahead_to_lookahead_if.master bus
);

    logic [1:0]            count;
    logic                  pending;
    logic [DATA_WIDTH-1:0] buf_q [2];

    logic       pop;
    logic [1:0] level;
    logic       slot;

    assign pop   = bus.rd & (count != 2'd0);
    // Occupancy once this cycle's arrival and pop are accounted for; an extra read
    // is only issued while that leaves room, so the buffer never overflows.
    assign level = count + {1'b0, pending} - {1'b0, pop};
    assign slot  = (count - {1'b0, pop}) != 2'd0;

    assign bus._rd   = rst_n & ~bus._empty & (level < 2'd2);
    assign bus.empty = (count == 2'd0);
    assign bus.dout  = buf_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            pending  <= 1'b0;
            // NOTE: the buffer is reset because dout is specified as 0 out of reset.
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            count   <= level;
            pending <= bus._rd;
            if (pop) begin
                buf_q[0] <= buf_q[1];
            end
            // Arrival after the shift: when both target slot 0 the new word must win.
            if (pending) begin
                buf_q[slot] <= bus._dout;
            end
        end
    end

endmodule

// File: tb/tb_fifo_nonlookahead_to_lookahead.sv
// Directed bench: behavioural registered-read upstream FIFO plus an in-order scoreboard.
module tb_fifo_nonlookahead_to_lookahead;

    logic clk;
    logic rst_n;

    fifo_nonlookahead_to_lookahead_if #(.DATA_WIDTH(32)) bus ();

    fifo_nonlookahead_to_lookahead #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors    = 0;
    int          checks    = 0;
    int          rd_pulses = 0;
    logic [31:0] up_q  [$];
    logic [31:0] exp_q [$];
    logic [31:0] words [8] = '{32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h81, 32'hE2, 32'hA0, 32'h7A};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        up_q.push_back(w);
        exp_q.push_back(w);
        bus._empty = 1'b0;
    endtask

    task automatic flush_upstream();
        up_q.delete();
        exp_q.delete();
        bus._dout  = '0;
        bus._empty = 1'b1;
    endtask

    // Advance one clock: sample mid-cycle, let the upstream FIFO answer an accepted
    // read with registered data, score any pop, and return just after the next negedge.
    task automatic step();
        logic        r;
        logic        p;
        logic [31:0] d;
        #1;
        r = bus._rd;
        p = rst_n & bus.rd & ~bus.empty;
        d = bus.dout;
        if (r) rd_pulses++;
        @(posedge clk);
        #1;
        if (r && up_q.size() > 0) bus._dout = up_q.pop_front();
        bus._empty = (up_q.size() == 0);
        if (p) begin
            if (exp_q.size() == 0) check("pop_underflow", 32'(exp_q.size()), 32'd1);
            else                   check("pop_data", d, exp_q.pop_front());
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.rd     = 1'b0;
        bus._dout  = '0;
        up_q.push_back(32'hA5);
        bus._empty = 1'b0;
        @(negedge clk);
        #1;

        // 1. Reset held for two cycles with upstream non-empty
        for (int i = 0; i < 2; i++) begin
            check("rst_empty", 32'(bus.empty), 32'd1);
            check("rst_dout", bus.dout, 32'h0);
            check("rst_rd_up", 32'(bus._rd), 32'd0);
            step();
        end
        rst_n = 1'b1;
        #1;
        check("rel_rd_up", 32'(bus._rd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rerst_rd_up", 32'(bus._rd), 32'd0);
        flush_upstream();
        step();
        rst_n = 1'b1;
        #1;
        check("rel_empty", 32'(bus.empty), 32'd1);

        // 2. Single word: fill latency of two cycles, then one pop
        push(32'h5A);
        #1;
        check("single_rd_up_c0", 32'(bus._rd), 32'd1);
        check("single_empty_c0", 32'(bus.empty), 32'd1);
        step();
        check("single_empty_c1", 32'(bus.empty), 32'd1);
        step();
        check("single_empty_c2", 32'(bus.empty), 32'd0);
        check("single_dout_c2", bus.dout, 32'h5A);
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        check("single_empty_after_pop", 32'(bus.empty), 32'd1);

        // 3. Streaming with rd held high: one word per cycle, no bubbles
        foreach (words[i]) push(words[i]);
        bus.rd = 1'b1;
        #1;
        check("stream_rd_up_c0", 32'(bus._rd), 32'd1);
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            check("stream_no_bubble", 32'(bus.empty), 32'd0);
            step();
        end
        check("stream_empty_end", 32'(bus.empty), 32'd1);
        check("stream_all_popped", 32'(exp_q.size()), 32'd0);

        // 4. Backpressure: only two upstream reads until the consumer pops
        bus.rd    = 1'b0;
        rd_pulses = 0;
        foreach (words[i]) push(words[i]);
        for (int i = 0; i < 6; i++) step();
        check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        check("bp_rd_up_held", 32'(bus._rd), 32'd0);
        check("bp_empty", 32'(bus.empty), 32'd0);
        check("bp_dout_stable", bus.dout, 32'h5A);
        bus.rd = 1'b1;
        #1;
        check("bp_rd_up_resume", 32'(bus._rd), 32'd1);
        step();
        check("bp_dout_next", bus.dout, 32'hF6);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        bus.rd = 1'b0;
        step();

        // 5. Random consumer against 1024 random words
        for (int i = 0; i < 1024; i++) push($urandom);
        for (int i = 0; i < 6000 && exp_q.size() > 0; i++) begin
            bus.rd = 1'($urandom_range(0, 1));
            step();
        end
        bus.rd = 1'b0;
        check("rand_all_popped", 32'(exp_q.size()), 32'd0);
        check("rand_upstream_drained", 32'(up_q.size()), 32'd0);
        check("rand_empty_end", 32'(bus.empty), 32'd1);

        // 6. Reset with one word buffered and one read in flight
        push(32'h21);
        push(32'h22);
        push(32'h23);
        step();
        step();
        check("mid_prefill_empty", 32'(bus.empty), 32'd0);
        check("mid_prefill_dout", bus.dout, 32'h21);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_rd_up", 32'(bus._rd), 32'd0);
        check("mid_rst_dout", bus.dout, 32'h0);
        flush_upstream();
        step();
        step();
        rst_n = 1'b1;
        push(32'h11);
        #1;
        check("restart_rd_up", 32'(bus._rd), 32'd1);
        step();
        check("restart_empty_c1", 32'(bus.empty), 32'd1);
        step();
        check("restart_empty_c2", 32'(bus.empty), 32'd0);
        check("restart_dout", bus.dout, 32'h11);
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        check("restart_empty_after_pop", 32'(bus.empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
